// File: rtl/axis2axi_in_sched.sv
// rtl/axis2axi_in_sched.sv - descriptor scheduler that sequences one axis2axi_in write datapath
// Optional macro AXIS2AXI_IN_SCHED_TLAST_EN adds s_axis_last_i for early buffer termination.
module axis2axi_in_sched #(
    parameter int AXI_ADDR_W = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int DESC_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [AXI_ADDR_W-1:0] desc_addr_i,
    input  logic [LEN_W-1:0]      desc_len_i,
    input  logic [DATA_W-1:0]     s_axis_data_i,
    input  logic                  s_axis_valid_i,
`ifdef AXIS2AXI_IN_SCHED_TLAST_EN
    input  logic                  s_axis_last_i,
`endif
    output logic                  s_axis_ready_o,
    output logic [DATA_W-1:0]     m_axis_data_o,
    output logic                  m_axis_valid_o,
    input  logic                  m_axis_ready_i,
    output logic [AXI_ADDR_W-1:0] cfg_addr_o,
    output logic                  cfg_valid_o,
    input  logic                  cfg_ready_i,
    output logic                  done_o,
    output logic [LEN_W-1:0]      done_len_o,
    output logic [DESC_W:0]       pending_o,
    output logic                  err_o
);
    localparam int DEPTH = 2 ** DESC_W;
    localparam logic [DESC_W:0] FULL = (DESC_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DRAIN} state_t;

    state_t                state;
    logic [AXI_ADDR_W-1:0] q_addr [DEPTH];
    logic [LEN_W-1:0]      q_len  [DEPTH];
    logic [DESC_W-1:0]     wr_ptr;
    logic [DESC_W-1:0]     rd_ptr;
    logic [DESC_W:0]       count;
    logic [LEN_W-1:0]      rem;
    logic [LEN_W-1:0]      cnt;
    logic                  drain_first;
    logic                  push;
    logic                  pop;
    logic                  beat;
    logic                  last_beat;

    assign desc_ready_o = (count != FULL);
    assign pending_o    = count;
    assign push         = desc_valid_i && desc_ready_o && (desc_len_i != '0);
    assign pop          = (state == DRAIN) && !drain_first && cfg_ready_i;

    assign m_axis_data_o  = s_axis_data_i;
    assign m_axis_valid_o = (state == STREAM) && s_axis_valid_i;
    assign s_axis_ready_o = (state == STREAM) && m_axis_ready_i;
    assign beat           = (state == STREAM) && s_axis_valid_i && m_axis_ready_i;
`ifdef AXIS2AXI_IN_SCHED_TLAST_EN
    assign last_beat = beat && ((rem == LEN_W'(1)) || s_axis_last_i);
`else
    assign last_beat = beat && (rem == LEN_W'(1));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else if (cke_i) begin
            if (push) begin
                q_addr[wr_ptr] <= desc_addr_i;
                q_len[wr_ptr]  <= desc_len_i;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (desc_valid_i && (!desc_ready_o || desc_len_i == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rem         <= '0;
            cnt         <= '0;
            drain_first <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_valid_o <= 1'b0;
            done_o      <= 1'b0;
            done_len_o  <= '0;
        end else if (cke_i) begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        rem        <= q_len[rd_ptr];
                        cnt        <= '0;
                        cfg_addr_o <= q_addr[rd_ptr];
                        state      <= CONFIG;
                    end
                end
                CONFIG: begin
                    if (cfg_valid_o) begin
                        cfg_valid_o <= 1'b0;
                        state       <= STREAM;
                    end else if (cfg_ready_i) begin
                        cfg_valid_o <= 1'b1;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        rem <= rem - 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                    if (last_beat) begin
                        drain_first <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // cfg_ready_i lags the final beat by a cycle, so skip the first look
                    if (drain_first) begin
                        drain_first <= 1'b0;
                    end else if (cfg_ready_i) begin
                        done_o     <= 1'b1;
                        done_len_o <= cnt;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis2axi_in_sched.sv
// tb/tb_axis2axi_in_sched.sv - self-checking bench for axis2axi_in_sched
// Exercises the early-end path when AXIS2AXI_IN_SCHED_TLAST_EN is defined.
module tb_axis2axi_in_sched;
    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_addr = '0;
    logic [15:0] desc_len = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] cfg_addr;
    logic        cfg_valid;
    logic        cfg_ready = 1'b0;
    logic        done;
    logic [15:0] done_len;
    logic [2:0]  pending;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axis2axi_in_sched dut (
        .clk_i          (clk),
        .cke_i          (cke),
        .rst_i          (rst),
        .desc_valid_i   (desc_valid),
        .desc_ready_o   (desc_ready),
        .desc_addr_i    (desc_addr),
        .desc_len_i     (desc_len),
        .s_axis_data_i  (s_data),
        .s_axis_valid_i (s_valid),
`ifdef AXIS2AXI_IN_SCHED_TLAST_EN
        .s_axis_last_i  (s_last),
`endif
        .s_axis_ready_o (s_ready),
        .m_axis_data_o  (m_data),
        .m_axis_valid_o (m_valid),
        .m_axis_ready_i (m_ready),
        .cfg_addr_o     (cfg_addr),
        .cfg_valid_o    (cfg_valid),
        .cfg_ready_i    (cfg_ready),
        .done_o         (done),
        .done_len_o     (done_len),
        .pending_o      (pending),
        .err_o          (err)
    );

    typedef struct {
        logic        rst;
        logic        dv;
        logic [31:0] addr;
        logic [15:0] len;
        logic [2:0]  exp_pending;
        logic        exp_ready;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    logic [31:0] got[$];
    logic [31:0] cfg_addrs[$];
    int          cfg_cyc[$];
    logic [15:0] done_lens[$];
    int          done_cyc[$];
    int          beat4_cyc;
    int          sent;
    logic [31:0] word_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [15:0] l);
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_len   = l;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic clear_logs();
        got.delete();
        cfg_addrs.delete();
        cfg_cyc.delete();
        done_lens.delete();
        done_cyc.delete();
        beat4_cyc = -1;
        sent      = 0;
    endtask

    // Plays source and a fake datapath whose cfg_ready drops for a few cycles after each beat.
    task automatic run(input int n_words, input int n_bufs, input bit rnd, input int stop_beats,
                       input int last_idx, input int max_cyc);
        int  busy;
        bit  fin;
        busy = 0;
        fin  = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            s_valid   = (sent < n_words) && (!rnd || ($urandom_range(0, 3) != 0));
            s_data    = word_base + 32'(sent);
            s_last    = (sent == last_idx);
            m_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_ready = (busy == 0);
            #1;
            if (m_valid && m_ready) got.push_back(m_data);
            if (s_valid && s_ready) begin
                sent++;
                busy = 4;
                if (sent == 4) beat4_cyc = cyc;
            end
            if (cfg_valid) begin
                cfg_addrs.push_back(cfg_addr);
                cfg_cyc.push_back(cyc);
            end
            if (done) begin
                done_lens.push_back(done_len);
                done_cyc.push_back(cyc);
            end
            if (busy > 0) busy--;
            if (done_lens.size() == n_bufs || (stop_beats != 0 && sent == stop_beats)) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got %0d done expected %0d", done_lens.size(), n_bufs);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_data(input string name, input int n);
        check({name, "_beats"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < got.size() && i < n; i++) begin
            check({name, "_data"}, got[i], word_base + 32'(i));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   16'd0, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h100, 16'd1, 3'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h200, 16'd2, 3'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h300, 16'd3, 3'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h400, 16'd4, 3'd4, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h500, 16'd5, 3'd4, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   16'd0, 3'd4, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   16'd0, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h700, 16'd7, 3'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h800, 16'd0, 3'd1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   16'd0, 3'd1, 1'b1, 1'b1};

        tick();
        tick();
        s_valid = 1'b1;
        m_ready = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_len", 32'(done_len), 32'd0);
        check("rst_cfg_addr", cfg_addr, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_desc_ready", 32'(desc_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        s_valid = 1'b0;
        m_ready = 1'b0;

        // Queue fill/overflow/zero-length vectors with cfg_ready held low so nothing pops
        for (int i = 0; i < 11; i++) begin
            rst        = vecs[i].rst;
            desc_valid = vecs[i].dv;
            desc_addr  = vecs[i].addr;
            desc_len   = vecs[i].len;
            cfg_ready  = 1'b0;
            tick();
            check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pending));
            check($sformatf("vec%0d_desc_ready", i), 32'(desc_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_cfg_valid", i), 32'(cfg_valid), 32'd0);
        end
        check("vec_cfg_addr_head", cfg_addr, 32'h700);
        desc_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Single buffer {0x1000, 8}
        clear_logs();
        word_base = 32'hA100_0000;
        push(32'h1000, 16'd8);
        run(8, 1, 1'b0, 0, -1, 200);
        check("t1_cfg_count", 32'(cfg_addrs.size()), 32'd1);
        if (cfg_addrs.size() > 0) check("t1_cfg_addr", cfg_addrs[0], 32'h1000);
        if (done_lens.size() > 0) check("t1_done_len", 32'(done_lens[0]), 32'd8);
        check_data("t1", 8);
        check("t1_pending", 32'(pending), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        tick();

        // Two queued buffers; second config must follow first done, 4th word stalls
        clear_logs();
        word_base = 32'hB200_0000;
        push(32'h1000, 16'd3);
        push(32'h2000, 16'd5);
        run(8, 2, 1'b0, 0, -1, 300);
        check("t2_cfg_count", 32'(cfg_addrs.size()), 32'd2);
        check("t2_done_count", 32'(done_lens.size()), 32'd2);
        if (cfg_addrs.size() == 2 && done_lens.size() == 2) begin
            check("t2_cfg_addr0", cfg_addrs[0], 32'h1000);
            check("t2_cfg_addr1", cfg_addrs[1], 32'h2000);
            check("t2_done_len0", 32'(done_lens[0]), 32'd3);
            check("t2_done_len1", 32'(done_lens[1]), 32'd5);
            check("t2_cfg_after_done", 32'(cfg_cyc[1] > done_cyc[0]), 32'd1);
            check("t2_word4_after_cfg", 32'(beat4_cyc > cfg_cyc[1]), 32'd1);
            check("t2_b2b_config", 32'(cfg_cyc[1] - done_cyc[0]), 32'd2);
        end
        check_data("t2", 8);
        check("t2_pending", 32'(pending), 32'd0);
        tick();

        // Random backpressure on {0x0, 16}
        clear_logs();
        word_base = 32'hC300_0000;
        push(32'h0, 16'd16);
        run(16, 1, 1'b1, 0, -1, 2000);
        if (done_lens.size() > 0) check("t4_done_len", 32'(done_lens[0]), 32'd16);
        check_data("t4", 16);
        check("t4_pending", 32'(pending), 32'd0);
        tick();

        // Reset during STREAM after 5 of 10 words
        clear_logs();
        word_base = 32'hD400_0000;
        push(32'h4000, 16'd10);
        run(10, 1, 1'b0, 5, -1, 200);
        check("t5_sent", 32'(sent), 32'd5);
        rst     = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        check("t5_s_ready", 32'(s_ready), 32'd0);
        check("t5_m_valid", 32'(m_valid), 32'd0);
        check("t5_cfg_valid", 32'(cfg_valid), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_pending", 32'(pending), 32'd0);
        check("t5_desc_ready", 32'(desc_ready), 32'd1);
        check("t5_cfg_addr", cfg_addr, 32'd0);
        rst       = 1'b0;
        cfg_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_done", 32'(done), 32'd0);
        end
        s_valid = 1'b0;

`ifdef AXIS2AXI_IN_SCHED_TLAST_EN
        // Early end on last flag at beat 4, then a clean following buffer
        clear_logs();
        word_base = 32'hE500_0000;
        push(32'h3000, 16'd10);
        push(32'h5000, 16'd2);
        run(6, 2, 1'b0, 0, 3, 300);
        check("t6_done_count", 32'(done_lens.size()), 32'd2);
        if (done_lens.size() == 2 && cfg_addrs.size() == 2) begin
            check("t6_done_len0", 32'(done_lens[0]), 32'd4);
            check("t6_done_len1", 32'(done_lens[1]), 32'd2);
            check("t6_cfg_addr1", cfg_addrs[1], 32'h5000);
        end
        check_data("t6", 6);
        check("t6_pending", 32'(pending), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
